gt_out_video_gen: RTL and testbench

- Video source producing the Gigatron 8-bit OUT-port stream on the HDMI pixel clock.
  - OUT[1:0] = R, OUT[3:2] = G, OUT[5:4] = B.
  - OUT[6] = HSYNC and OUT[7] = VSYNC, both active-low.
- Purpose: stand-in/test source for the OUT→HDMI conversion path, and a bridge from an RGB888 pixel producer (framebuffer reader, pattern source) onto the OUT-port format.
- Generates line/frame timing, pulls pixels over a ready/valid handshake during active video, and quantizes each 8-bit channel to 2 bits.

---
 rtl/gt_video_pkg.sv | 38 +++
 rtl/gt_video_timing.sv | 67 ++++++
 rtl/gt_out_video_gen.sv | 110 +++++++++++
 tb/tb_gt_out_video_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gt_video_pkg.sv
`default_nettype none
// ============================================================================
// gt_video_pkg : OUT-port field map, FSM states and channel quantizer
// Revision     : 1.0
// ============================================================================
package gt_video_pkg;

  localparam int OUT_R_LSB = 0;
  localparam int OUT_G_LSB = 2;
  localparam int OUT_B_LSB = 4;
  localparam int OUT_HS    = 6;
  localparam int OUT_VS    = 7;

  localparam logic [7:0] OUT_IDLE = 8'hC0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  // 2x2 Bayer thresholds indexed by {v[0], h[0]}
  localparam logic [3:0][7:0] BAYER = {8'd16, 8'd48, 8'd32, 8'd0};

`ifdef GT_OUT_DITHER_EN
  function automatic logic [1:0] quant(input logic [7:0] x, input logic [1:0] idx);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, BAYER[idx]};
    return s[8] ? 2'b11 : s[7:6];
  endfunction
`else
  function automatic logic [1:0] quant(input logic [7:0] x);
    return 2'(x >> 6);
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/gt_video_timing.sv
`default_nettype none
// ============================================================================
// gt_video_timing : h/v raster counters with region decodes
// Revision        : 1.0
// ============================================================================
module gt_video_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          h_active,
  output logic          v_active,
  output logic          h_sync,
  output logic          v_sync,
  output logic          frame_last
);

  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST     = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic h_last;
  logic v_last;

  assign h_last     = (h_cnt == H_LAST);
  assign v_last     = (v_cnt == V_LAST);
  assign frame_last = h_last && v_last;
  assign h_active   = (h_cnt < H_ACT_END);
  assign v_active   = (v_cnt < V_ACT_END);
  assign h_sync     = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign v_sync     = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  // Counters are pinned at the frame origin whenever the generator is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!advance) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gt_out_video_gen.sv
`default_nettype none
// ============================================================================
// gt_out_video_gen : RGB888 ready/valid source -> Gigatron OUT-port byte stream
// Optional 2x2 ordered dither when GT_OUT_DITHER_EN is defined.
// Revision         : 1.0
// ============================================================================
module gt_out_video_gen
  import gt_video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       hdmi_pixel_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       pix_valid,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  output logic       pix_ready,
  input  logic       underflow_clr,
  output logic       underflow,
  output logic       frame_start,
  output logic [7:0] OUT
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  state_t        state;
  logic          advance;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_active, v_active, h_sync, v_sync, frame_last;
  logic          take;
  logic [7:0]    out_next;

  assign advance = (state != ST_IDLE);

  gt_video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk        (hdmi_pixel_clk),
    .rst_n      (rst_n),
    .advance    (advance),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .h_active   (h_active),
    .v_active   (v_active),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .frame_last (frame_last)
  );

  assign pix_ready = advance && h_active && v_active;
  assign take      = pix_ready && pix_valid;

  always_comb begin
    out_next         = '0;
    out_next[OUT_HS] = ~h_sync;
    out_next[OUT_VS] = ~v_sync;
    if (take) begin
`ifdef GT_OUT_DITHER_EN
      out_next[OUT_R_LSB +: 2] = quant(pix_r, {v_cnt[0], h_cnt[0]});
      out_next[OUT_G_LSB +: 2] = quant(pix_g, {v_cnt[0], h_cnt[0]});
      out_next[OUT_B_LSB +: 2] = quant(pix_b, {v_cnt[0], h_cnt[0]});
`else
      out_next[OUT_R_LSB +: 2] = quant(pix_r);
      out_next[OUT_G_LSB +: 2] = quant(pix_g);
      out_next[OUT_B_LSB +: 2] = quant(pix_b);
`endif
    end
  end

  // STOP keeps scanning so the current frame always finishes intact
  always_ff @(posedge hdmi_pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      OUT         <= OUT_IDLE;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (enable) state <= ST_RUN;
        ST_RUN:  if (!enable) state <= ST_STOP;
        ST_STOP: begin
          if (enable)          state <= ST_RUN;
          else if (frame_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      OUT         <= advance ? out_next : OUT_IDLE;
      frame_start <= advance && (h_cnt == '0) && (v_cnt == '0);

      if (pix_ready && !pix_valid) underflow <= 1'b1;
      else if (underflow_clr)      underflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gt_out_video_gen.sv
`default_nettype none
// ============================================================================
// tb_gt_out_video_gen : randomized stimulus against a raster-position model
// Revision            : 1.0
// ============================================================================
module tb_gt_out_video_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n, enable, pix_valid, underflow_clr;
  logic [7:0] pix_r, pix_g, pix_b;
  logic       pix_ready, underflow, frame_start;
  logic [7:0] out_byte;

  always #5 clk = ~clk;

  gt_out_video_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .hdmi_pixel_clk (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .pix_valid      (pix_valid),
    .pix_r          (pix_r),
    .pix_g          (pix_g),
    .pix_b          (pix_b),
    .pix_ready      (pix_ready),
    .underflow_clr  (underflow_clr),
    .underflow      (underflow),
    .frame_start    (frame_start),
    .OUT            (out_byte)
  );

  int checks = 0;
  int errors = 0;

  // model: mode 0=idle 1=run 2=stop, pos = linear raster position in the frame
  int         m_mode, m_pos;
  logic [7:0] e_out;
  logic       e_fs, e_uf;

  bit counting = 0;
  int n_hs, n_vs, n_rdy, n_fs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qm(input int x, input int h, input int v);
`ifdef GT_OUT_DITHER_EN
    int tab[4] = '{0, 32, 48, 16};
    x = x + tab[(v % 2) * 2 + (h % 2)];
    if (x > 255) x = 255;
`endif
    return x / 64;
  endfunction

  function automatic bit model_ready();
    return (m_mode != 0) && (m_pos % HT < HA) && (m_pos / HT < VA);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; e_out = 8'hC0; e_fs = 1'b0; e_uf = 1'b0;
  endtask

  task automatic model_step();
    int h, v;
    bit act, rdy;
    h   = m_pos % HT;
    v   = m_pos / HT;
    act = (m_mode != 0);
    rdy = model_ready();
    if (!act) e_out = 8'hC0;
    else begin
      e_out[7] = !(v >= VA + VF && v < VA + VF + VS);
      e_out[6] = !(h >= HA + HF && h < HA + HF + HS);
      if (rdy && pix_valid)
        e_out[5:0] = {2'(qm(pix_b, h, v)), 2'(qm(pix_g, h, v)), 2'(qm(pix_r, h, v))};
      else
        e_out[5:0] = 6'd0;
    end
    e_fs = act && (m_pos == 0);
    if (rdy && !pix_valid) e_uf = 1'b1;
    else if (underflow_clr) e_uf = 1'b0;
    case (m_mode)
      0:       m_mode = enable ? 1 : 0;
      1:       m_mode = enable ? 1 : 2;
      default: m_mode = enable ? 1 : ((m_pos == FT - 1) ? 0 : 2);
    endcase
    m_pos = act ? (m_pos + 1) % FT : 0;
  endtask

  task automatic compare();
    check("OUT", 32'(out_byte), 32'(e_out));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("underflow", 32'(underflow), 32'(e_uf));
    check("pix_ready", 32'(pix_ready), 32'(model_ready()));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
    if (counting) begin
      n_hs  += (out_byte[6] == 1'b0) ? 1 : 0;
      n_vs  += (out_byte[7] == 1'b0) ? 1 : 0;
      n_rdy += pix_ready ? 1 : 0;
      n_fs  += frame_start ? 1 : 0;
    end
  endtask

  task automatic rand_pix();
    pix_r = 8'($urandom); pix_g = 8'($urandom); pix_b = 8'($urandom);
  endtask

  // advance until the model is about to process raster position p while running
  task automatic wait_pos(input int p, input string name);
    int k;
    for (k = 0; k < 4 * FT && !(m_mode == 1 && m_pos == p); k++) begin
      rand_pix();
      tick();
    end
    check(name, 32'(m_mode == 1 && m_pos == p), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; pix_valid = 1'b0; underflow_clr = 1'b0;
    pix_r = '0; pix_g = '0; pix_b = '0;
    model_reset();
    @(negedge clk);
    check("reset_OUT", 32'(out_byte), 32'h0C0);
    check("reset_pix_ready", 32'(pix_ready), 32'd0);
    check("reset_frame_start", 32'(frame_start), 32'd0);
    check("reset_underflow", 32'(underflow), 32'd0);
    rst_n = 1'b1;

    // continuous run, always-valid producer; measure one full frame period
    enable = 1'b1; pix_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin rand_pix(); tick(); end
    n_hs = 0; n_vs = 0; n_rdy = 0; n_fs = 0; counting = 1;
    for (int i = 0; i < FT; i++) begin rand_pix(); tick(); end
    counting = 0;
    check("hsync_low_per_frame", 32'(n_hs), 32'(HS * VT));
    check("vsync_low_per_frame", 32'(n_vs), 32'(VS * HT));
    check("ready_per_frame", 32'(n_rdy), 32'(HA * VA));
    check("frame_start_per_frame", 32'(n_fs), 32'd1);

    // quantization of a fixed colour at pixel 0 and at h=1,v=1
    wait_pos(0, "reach_pixel0");
    pix_r = 8'hC0; pix_g = 8'h80; pix_b = 8'h7F;
    tick();
    check("quant_pixel0", 32'(out_byte[5:0]), 32'b011011);
    wait_pos(HT + 1, "reach_h1v1");
    pix_r = 8'hC0; pix_g = 8'h80; pix_b = 8'h7F;
    tick();
`ifdef GT_OUT_DITHER_EN
    check("quant_h1v1", 32'(out_byte[5:0]), 32'b101011);
`else
    check("quant_h1v1", 32'(out_byte[5:0]), 32'b011011);
`endif

    // three starved slots, then clear colliding with a fresh underflow
    wait_pos(0, "reach_underflow");
    pix_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_pix(); tick();
      check("starved_colour", 32'(out_byte[5:0]), 32'd0);
      check("starved_flag", 32'(underflow), 32'd1);
    end
    underflow_clr = 1'b1; tick();
    check("set_beats_clear", 32'(underflow), 32'd1);
    pix_valid = 1'b1; tick();
    check("clear_works", 32'(underflow), 32'd0);
    underflow_clr = 1'b0;

    // randomized enable / valid / clear traffic
    for (int i = 0; i < 1200; i++) begin
      rand_pix();
      enable        = ($urandom_range(0, 29) != 0);
      pix_valid     = ($urandom_range(0, 9) != 0);
      underflow_clr = ($urandom_range(0, 9) == 0);
      tick();
    end
    enable = 1'b1; pix_valid = 1'b1; underflow_clr = 1'b0;

    // stop request mid-frame drains the frame then idles
    wait_pos(HT + 2, "reach_stop_point");
    enable = 1'b0;
    for (int k = 0; k < 2 * FT && m_mode != 0; k++) begin rand_pix(); tick(); end
    check("stop_reaches_idle", 32'(m_mode), 32'd0);
    for (int i = 0; i < 4; i++) begin rand_pix(); tick(); end
    check("idle_OUT", 32'(out_byte), 32'h0C0);

    // brief enable drop inside a frame resumes without a break
    enable = 1'b1;
    wait_pos(10, "reach_resume_point");
    enable = 1'b0; tick();
    enable = 1'b1;
    for (int i = 0; i < FT + 5; i++) begin rand_pix(); tick(); end

    // asynchronous reset in the middle of an active line, flag set beforehand
    wait_pos(HT + 1, "reach_reset_point");
    pix_valid = 1'b0; tick();
    pix_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_OUT", 32'(out_byte), 32'h0C0);
    check("async_pix_ready", 32'(pix_ready), 32'd0);
    check("async_underflow", 32'(underflow), 32'd0);
    check("async_frame_start", 32'(frame_start), 32'd0);
    model_reset();
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    compare();
    enable = 1'b1;
    for (int i = 0; i < FT + 4; i++) begin rand_pix(); tick(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
